// File: rtl/cacheline_adaptor_param_if.sv
// Cache-side and memory-side signals of the cacheline adaptor.
// The slave modport is the adaptor's view; master is the requester/memory view.
interface cacheline_adaptor_param_if #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
);
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic [ADDR_W-1:0]  wb_address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic               busy_o;
  logic               resp_i;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;

  modport slave (
    input  line_i, address_i, wb_address_i, read_i, write_i, resp_i, burst_i,
    output line_o, resp_o, busy_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, wb_address_i, read_i, write_i, resp_i, burst_i,
    input  line_o, resp_o, busy_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor_param.sv
// Splits one cache line into LINE_W/BURST_W memory beats: optional writeback,
// optional refill, or writeback followed by refill. All outputs are registered.
module cacheline_adaptor_param #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  parameter int unsigned ADDR_W  = 32
) (
  input logic                      clk,
  input logic                      reset,
  cacheline_adaptor_param_if.slave bus
);
  localparam int unsigned Beats = LINE_W / BURST_W;
  localparam int unsigned Off   = $clog2(LINE_W / 8);
  localparam int unsigned CntW  = $clog2(Beats);

  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t LastBeat = cnt_t'(Beats - 1);

  typedef enum logic [2:0] {StIdle, StWb, StTurn, StFill, StDone} state_e;

  state_e             state_q, state_d;
  cnt_t               cnt_q, cnt_d;
  logic [LINE_W-1:0]  wbuf_q, wbuf_d;
  logic [LINE_W-1:0]  rbuf_q, rbuf_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic               pend_rd_q, pend_rd_d;
  logic               resp_q, resp_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               busy_q, busy_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [ADDR_W-1:0]  address_q, address_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wbuf_d    = wbuf_q;
    rbuf_d    = rbuf_q;
    rd_addr_d = rd_addr_q;
    wb_addr_d = wb_addr_q;
    pend_rd_d = pend_rd_q;

    unique case (state_q)
      StIdle: begin
        if (bus.read_i || bus.write_i) begin
          wbuf_d              = bus.line_i;
          rd_addr_d           = bus.address_i;
          rd_addr_d[Off-1:0]  = '0;
          wb_addr_d           = bus.wb_address_i;
          wb_addr_d[Off-1:0]  = '0;
          pend_rd_d           = bus.read_i;
          state_d             = bus.write_i ? StWb : StFill;
        end
      end
      StWb: begin
        if (bus.resp_i) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = pend_rd_q ? StTurn : StDone;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end
      StTurn: state_d = StFill;
      StFill: begin
        if (bus.resp_i) begin
          rbuf_d[cnt_q * BURST_W +: BURST_W] = bus.burst_i;
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs follow the next state so they are valid in the cycle that state is entered.
    resp_d    = (state_d == StDone);
    read_d    = (state_d == StFill);
    write_d   = (state_d == StWb);
    busy_d    = (state_d != StIdle);
    burst_d   = (state_d == StWb) ? wbuf_d[cnt_d * BURST_W +: BURST_W] : '0;
    address_d = (state_d == StWb)   ? wb_addr_d :
                (state_d == StFill) ? rd_addr_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wbuf_q    <= '0;
      rbuf_q    <= '0;
      rd_addr_q <= '0;
      wb_addr_q <= '0;
      pend_rd_q <= 1'b0;
      resp_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      burst_q   <= '0;
      address_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wbuf_q    <= wbuf_d;
      rbuf_q    <= rbuf_d;
      rd_addr_q <= rd_addr_d;
      wb_addr_q <= wb_addr_d;
      pend_rd_q <= pend_rd_d;
      resp_q    <= resp_d;
      read_q    <= read_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      burst_q   <= burst_d;
      address_q <= address_d;
    end
  end

  assign bus.resp_o    = resp_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.busy_o    = busy_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = address_q;
  assign bus.line_o    = rbuf_q;
endmodule

// File: tb/tb_cacheline_adaptor_param.sv
// Bench for cacheline_adaptor_param: vector table, directed corner sequences and random
// operations checked cycle by cycle against a beat-counting model of the memory protocol.
module tb_cacheline_adaptor_param;
  localparam int unsigned LineW  = 256;
  localparam int unsigned BurstW = 64;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned Beats  = LineW / BurstW;
  localparam int unsigned Off    = $clog2(LineW / 8);
  localparam logic [31:0] AddrMask = (32'd1 << Off) - 32'd1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cacheline_adaptor_param_if #(.LINE_W(LineW), .BURST_W(BurstW), .ADDR_W(AddrW)) b ();
  cacheline_adaptor_param #(.LINE_W(LineW), .BURST_W(BurstW), .ADDR_W(AddrW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  cacheline_adaptor_param_if #(.LINE_W(128), .BURST_W(32), .ADDR_W(32)) pb ();
  cacheline_adaptor_param #(.LINE_W(128), .BURST_W(32), .ADDR_W(32)) u_dut128 (
    .clk   (clk),
    .reset (reset),
    .bus   (pb.slave)
  );

  int n_pass = 0;
  int n_total = 0;
  logic [255:0] exp_rbuf;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic idle_cycles(input int n);
    int e = 0;
    for (int i = 0; i < n; i++) begin
      b.read_i  = 1'b0;
      b.write_i = 1'b0;
      b.resp_i  = 1'($urandom_range(0, 1));
      b.burst_i = {$urandom(), $urandom()};
      @(posedge clk); #1;
      if (b.busy_o !== 1'b0 || b.resp_o !== 1'b0 || b.read_o !== 1'b0 ||
          b.write_o !== 1'b0 || b.burst_o !== '0 || b.address_o !== '0 ||
          b.line_o !== exp_rbuf) e++;
    end
    check("idle_quiet", e, 0);
  endtask

  // One operation. The model tracks beats acknowledged per phase and derives from that
  // which of write/turn/read/done the adaptor must be showing in every cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [255:0] line,
                        input logic [31:0] addr, input logic [31:0] wbaddr,
                        input logic [31:0] exp_ra, input logic [31:0] exp_wa,
                        input int mode, input bit fixed_rd, output int dut_lat);
    logic [255:0] rline = '0;
    logic [63:0]  bi;
    logic         ack, ew, er, eresp;
    int wacks = 0, racks = 0, cyc = 0;
    int e_phase = 0, e_wb = 0, e_addr = 0;
    bit turn = 0, done = 0;
    dut_lat = -1;
    b.read_i       = rd;
    b.write_i      = wr;
    b.line_i       = line;
    b.address_i    = addr;
    b.wb_address_i = wbaddr;
    b.resp_i       = 1'($urandom_range(0, 1));
    b.burst_i      = {$urandom(), $urandom()};
    while (!done && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      ew = wr && (wacks < Beats);
      er = 1'b0;
      eresp = 1'b0;
      if (!ew) begin
        if (turn) turn = 0;
        else if (rd && racks < Beats) er = 1'b1;
        else eresp = 1'b1;
      end
      if (b.resp_o === 1'b1 && dut_lat < 0) dut_lat = cyc;
      if (b.write_o !== ew || b.read_o !== er || b.resp_o !== eresp || b.busy_o !== 1'b1)
        e_phase++;
      if (ew && (b.address_o !== exp_wa || b.burst_o !== line[wacks*BurstW +: BurstW])) e_wb++;
      if (er && b.address_o !== exp_ra) e_addr++;
      if (eresp) begin
        done = 1;
        if (rd) exp_rbuf = rline;
        check("line_o", b.line_o, exp_rbuf);
      end
      case (mode)
        0:       ack = 1'b1;
        1:       ack = (cyc % 2 == 0);
        default: ack = 1'($urandom_range(0, 1));
      endcase
      bi = fixed_rd ? {16{4'(racks + 1)}} : {$urandom(), $urandom()};
      b.resp_i  = ack;
      b.burst_i = bi;
      if (ack && ew) begin
        wacks++;
        if (wacks == Beats && rd) turn = 1;
      end
      if (ack && er) begin
        rline[racks*BurstW +: BurstW] = bi;
        racks++;
      end
      if (eresp) begin
        b.read_i  = 1'b0;
        b.write_i = 1'b0;
      end else begin
        b.read_i       = 1'($urandom_range(0, 1));
        b.write_i      = 1'($urandom_range(0, 1));
        b.line_i       = rand_line();
        b.address_i    = $urandom();
        b.wb_address_i = $urandom();
      end
    end
    check("op_done", done, 1);
    check("phase", e_phase, 0);
    check("wb_beat", e_wb, 0);
    check("rd_addr", e_addr, 0);
    b.resp_i = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check("post_idle", {b.busy_o, b.resp_o, b.read_o, b.write_o}, 4'b0000);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wbaddr;
    logic [31:0] exp_ra;
    logic [31:0] exp_wa;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int lat, k, e, plat;
    logic [1:0] sel;
    logic [31:0] ra, wa;

    vecs[0] = '{1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5660, 32'h0, 5};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0000, 32'h8000_003F, 32'h0, 32'h8000_0020, 5};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0200, 32'h100, 32'h200, 10};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFE0, 32'h0, 5};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_001F, 32'h0, 32'h0, 5};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_003F, 32'h7FFF_FFE1, 32'h20, 32'h7FFF_FFE0, 10};

    b.read_i = 0; b.write_i = 0; b.resp_i = 0; b.burst_i = '0;
    b.line_i = '0; b.address_i = '0; b.wb_address_i = '0;
    pb.read_i = 0; pb.write_i = 0; pb.resp_i = 0; pb.burst_i = '0;
    pb.line_i = '0; pb.address_i = '0; pb.wb_address_i = '0;
    exp_rbuf = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {b.resp_o, b.read_o, b.write_o, b.busy_o}, 4'b0000);
    check("rst_burst", b.burst_o, 0);
    check("rst_addr", b.address_o, 0);
    check("rst_line", b.line_o, 0);
    reset = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, rand_line(), vecs[i].addr, vecs[i].wbaddr,
             vecs[i].exp_ra, vecs[i].exp_wa, 0, (i == 0), lat);
      check("latency", lat, vecs[i].exp_lat);
    end

    // Writeback with memory acknowledging every second cycle; beats A, B, C, D.
    run_op(1'b0, 1'b1, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 32'h0,
           32'h8000_003F, 32'h0, 32'h8000_0020, 1, 1'b0, lat);
    check("stall_lat", lat, 9);

    // Reset after two fill beats abandons the fill.
    b.read_i = 1'b1; b.address_i = 32'h40; b.resp_i = 1'b1; b.burst_i = {16{4'h9}};
    @(posedge clk); #1;
    b.read_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_fill_read_o", b.read_o, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    b.resp_i = 1'b0;
    exp_rbuf = '0;
    check("mrst_ctrl", {b.resp_o, b.read_o, b.write_o, b.busy_o}, 4'b0000);
    check("mrst_addr", b.address_o, 0);
    check("mrst_line", b.line_o, 0);
    idle_cycles(2);
    run_op(1'b1, 1'b0, rand_line(), 32'h40, 32'h0, 32'h40, 32'h0, 0, 1'b1, lat);
    check("after_rst_lat", lat, 5);

    // Narrow instance: 128-bit line of 32-bit beats.
    pb.read_i = 1'b1; pb.address_i = 32'hABCD; pb.resp_i = 1'b1;
    k = 0; e = 0; plat = -1;
    for (int c = 1; c <= 20 && plat < 0; c++) begin
      @(posedge clk); #1;
      pb.read_i = 1'b0;
      if (pb.read_o === 1'b1) begin
        if (pb.address_o !== 32'hABC0) e++;
        pb.burst_i = 32'(k + 1);
        k++;
      end
      if (pb.resp_o === 1'b1) begin
        plat = c;
        check("p_line", pb.line_o, 128'h00000004_00000003_00000002_00000001);
      end
    end
    pb.resp_i = 1'b0;
    check("p_addr", e, 0);
    check("p_beats", k, 4);
    check("p_lat", plat, 5);

    for (int i = 0; i < 30; i++) begin
      sel = 2'($urandom_range(1, 3));
      ra = $urandom();
      wa = $urandom();
      run_op(sel[0], sel[1], rand_line(), ra, wa, ra & ~AddrMask, wa & ~AddrMask, 2, 1'b0,
             lat);
      idle_cycles($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/cacheline_adaptor_param.md
Name: cacheline_adaptor_param

Overview:
Parametrised successor to the fixed 256/64-bit cacheline adaptor. It sits between the last-level cache and the burst memory port, and converts one LINE_W-bit cache line into BEATS = LINE_W/BURST_W memory beats. New capabilities:
- generic widths with a beat counter;
- write data and addresses latched at request acceptance;
- a combined evict-then-fill operation (writeback followed by refill in one request);
- a line-aligned address_o.

Parameters:
LINE_W, 256, cache line width in bits; must be an integer multiple of BURST_W, and LINE_W/BURST_W >= 2.
BURST_W, 64, memory beat width in bits.
ADDR_W, 32, address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset; reset==0 at a rising edge resets the block.
line_i  in  LINE_W  writeback line data; sampled only at acceptance.
line_o  out  LINE_W  fill line data; valid while resp_o=1 for a read.
address_i  in  ADDR_W  fill (read) address.
wb_address_i  in  ADDR_W  writeback address.
read_i  in  1  fill request.
write_i  in  1  writeback request.
resp_o  out  1  one-cycle completion pulse.
busy_o  out  1  high in every state except IDLE.
resp_i  in  1  memory beat acknowledge.
burst_i  in  BURST_W  memory read beat.
burst_o  out  BURST_W  memory write beat.
address_o  out  ADDR_W  line-aligned memory address.
read_o  out  1  memory read request.
write_o  out  1  memory write request.

Behaviour:
- OFF = log2(LINE_W/8). Latched addresses have bits [OFF-1:0] forced to 0.
- Beat k occupies bits [k*BURST_W +: BURST_W]; beat 0 is transferred first.
- Reset (reset==0 at a clock edge): state=IDLE, beat count=0, rbuf=0, wbuf=0, pending flags cleared.
  - All outputs are 0: resp_o, read_o, write_o, busy_o, burst_o, address_o, line_o.
  - Reset mid-transfer abandons the transfer immediately; no resp_o is issued.
- States: IDLE, WB, TURN, FILL, DONE.
- IDLE: outputs as in reset, except line_o=rbuf.
  - On read_i|write_i: latch wbuf=line_i, rd_addr, wb_addr, and pend_rd=read_i.
  - write_i=1 -> WB. Otherwise read_i=1 -> FILL.
- WB:
  - write_o=1, address_o=wb_addr, burst_o=wbuf beat[cnt].
  - On resp_i: if cnt==BEATS-1, set cnt=0 and go to TURN if pend_rd, else DONE. Otherwise cnt++.
- TURN: exactly one cycle with read_o=write_o=0, then FILL. Memory therefore sees write_o fall before read_o rises.
- FILL:
  - read_o=1, address_o=rd_addr.
  - On resp_i: rbuf beat[cnt]=burst_i. If cnt==BEATS-1, set cnt=0 and go to DONE. Otherwise cnt++.
- DONE: resp_o=1 for exactly one cycle, read_o=write_o=0, then IDLE.
- Request holding:
  - read_i/write_i/line_i/addresses may change freely after acceptance.
  - The requester must deassert read_i/write_i in the cycle resp_o is high; IDLE samples them again on the next cycle.
- resp_i is ignored in IDLE, TURN and DONE.
- read_o and write_o are never high together.
- read_o/write_o stay high continuously from the first beat through the cycle of the final resp_i.
- Latency with resp_i tied high:
  - read only: BEATS+1 cycles from acceptance to resp_o;
  - write only: BEATS+1 cycles;
  - combined: 2*BEATS+2 cycles.
- line_o holds rbuf between operations. A write-only operation leaves rbuf unchanged.

Test Plan:
- Read, defaults: read_i=1, address_i=0x1234_5678, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with resp_i high -> address_o=0x1234_5660, read_o high for 4 cycles, resp_o pulses on cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
- Write with stalls: write_i=1, wb_address_i=0x8000_003F, line_i beats A,B,C,D; resp_i high on every 2nd cycle -> address_o=0x8000_0020, burst_o holds A until the first resp_i, then B, C, D in order; one resp_o; line_i changed after acceptance has no effect.
- Combined: read_i=write_i=1, rd 0x100, wb 0x200 -> 4 write beats at 0x200, one cycle with read_o=write_o=0, 4 read beats at 0x100, resp_o on cycle 10, exclusivity holds throughout.
- Reset mid-fill: reset=0 after 2 read beats -> next cycle all outputs 0 and line_o=0; a new read then completes normally starting from beat 0.
- Parametrisation: LINE_W=128, BURST_W=32 -> 4 beats, OFF=4; read of 0xABCD with beats 1,2,3,4 -> address_o=0xABC0, line_o=0x00000004_00000003_00000002_00000001.
- Spurious resp_i in IDLE, TURN and DONE -> no state change, no extra resp_o, beat count unchanged.
